// File: rtl/adma_atx_ostd_ctrl.sv
// ---------------------------------------------------------------------------
// adma_atx_ostd_ctrl
// Outstanding-transaction controller between the DMA AXI transaction
// scheduler and the AXI AR/AW issue stage. A scheduled transaction is only
// passed on while both the global and the per-channel in-flight counts are
// below their limits. Completion IDs are mapped back to their owning channel,
// which decrements the counts and raises a one-cycle atx_done pulse.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   bwd_atx_chn_id  channel of the offered transaction
//   bwd_atx_vld     scheduler offers a transaction
//   bwd_atx_rdy     transaction accepted toward AXI (combinational)
//   fwd_atx_vld     transaction forwarded to AXI issue stage (combinational)
//   fwd_atx_rdy     AXI issue stage ready
//   atx_id          per-channel AXI ID, static while the channel is busy
//   cpl_id, cpl_vld completion ID and one-cycle completion strobe
//   atx_done        per-channel registered completion pulse
//   chn_ostd_cnt    per-channel in-flight count (registered)
//   ostd_cnt        total in-flight count (registered)
//   idle            registered, high when ostd_cnt is zero
//   cpl_err         sticky unmatched/surplus completion flag
//   err_clr         clears cpl_err (a new error in the same cycle wins)
// ---------------------------------------------------------------------------
module adma_atx_ostd_ctrl #(
  parameter int DMA_CHN_NUM   = 4,
  parameter int MST_ID_W      = 5,
  parameter int ATX_NUM_OSTD  = 4,
  parameter int CHN_OSTD_MAX  = 2,
  parameter int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM),
  parameter int OSTD_CNT_W    = $clog2(ATX_NUM_OSTD + 1),
  parameter int CHN_CNT_W     = $clog2(CHN_OSTD_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DMA_CHN_NUM_W-1:0] bwd_atx_chn_id,
  input  logic                     bwd_atx_vld,
  output logic                     bwd_atx_rdy,
  output logic                     fwd_atx_vld,
  input  logic                     fwd_atx_rdy,
  input  logic [MST_ID_W-1:0]      atx_id [0:DMA_CHN_NUM-1],
  input  logic [MST_ID_W-1:0]      cpl_id,
  input  logic                     cpl_vld,
  output logic                     atx_done [0:DMA_CHN_NUM-1],
  output logic [CHN_CNT_W-1:0]     chn_ostd_cnt [0:DMA_CHN_NUM-1],
  output logic [OSTD_CNT_W-1:0]    ostd_cnt,
  output logic                     idle,
  output logic                     cpl_err,
  input  logic                     err_clr
);

  logic                     grant_ok_s;
  logic                     issue_s;
  logic                     match_vld_s;
  logic [DMA_CHN_NUM_W-1:0] match_chn_s;
  logic                     cpl_ok_s;
  logic [OSTD_CNT_W-1:0]    ostd_nxt_s;
  logic [CHN_CNT_W-1:0]     chn_nxt_s [0:DMA_CHN_NUM-1];
  logic                     chn_dec_s [0:DMA_CHN_NUM-1];

  // Credit check on registered counts; a freed credit is seen one cycle later.
  always_comb begin
    grant_ok_s  = (ostd_cnt < OSTD_CNT_W'(ATX_NUM_OSTD)) &&
                  (chn_ostd_cnt[bwd_atx_chn_id] < CHN_CNT_W'(CHN_OSTD_MAX));
    fwd_atx_vld = bwd_atx_vld & grant_ok_s;
    bwd_atx_rdy = fwd_atx_rdy & grant_ok_s;
    issue_s     = bwd_atx_vld & bwd_atx_rdy;
  end

  // Completion match: lowest channel with this ID that still has work in
  // flight. Scanning downward lets the lowest hit overwrite higher ones.
  always_comb begin
    match_vld_s = 1'b0;
    match_chn_s = {DMA_CHN_NUM_W{1'b0}};
    for (int c = DMA_CHN_NUM - 1; c >= 0; c--) begin
      if ((atx_id[c] == cpl_id) && (chn_ostd_cnt[c] != {CHN_CNT_W{1'b0}})) begin
        match_vld_s = 1'b1;
        match_chn_s = DMA_CHN_NUM_W'(c);
      end else begin
        match_vld_s = match_vld_s;
        match_chn_s = match_chn_s;
      end
    end
    cpl_ok_s = cpl_vld & match_vld_s;
  end

  // Next-state counts; an issue and a completion in one cycle cancel out.
  always_comb begin
    case ({issue_s, cpl_ok_s})
      2'b10:   ostd_nxt_s = ostd_cnt + OSTD_CNT_W'(1);
      2'b01:   ostd_nxt_s = ostd_cnt - OSTD_CNT_W'(1);
      default: ostd_nxt_s = ostd_cnt;
    endcase
    for (int c = 0; c < DMA_CHN_NUM; c++) begin
      chn_dec_s[c] = cpl_ok_s && (match_chn_s == DMA_CHN_NUM_W'(c));
      case ({issue_s && (bwd_atx_chn_id == DMA_CHN_NUM_W'(c)), chn_dec_s[c]})
        2'b10:   chn_nxt_s[c] = chn_ostd_cnt[c] + CHN_CNT_W'(1);
        2'b01:   chn_nxt_s[c] = chn_ostd_cnt[c] - CHN_CNT_W'(1);
        default: chn_nxt_s[c] = chn_ostd_cnt[c];
      endcase
    end
  end

  // Counter, pulse and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ostd_cnt <= {OSTD_CNT_W{1'b0}};
      idle     <= 1'b1;
      cpl_err  <= 1'b0;
      for (int c = 0; c < DMA_CHN_NUM; c++) begin
        chn_ostd_cnt[c] <= {CHN_CNT_W{1'b0}};
        atx_done[c]     <= 1'b0;
      end
    end else begin
      ostd_cnt <= ostd_nxt_s;
      idle     <= (ostd_nxt_s == {OSTD_CNT_W{1'b0}});
      if (cpl_vld && !match_vld_s) begin
        cpl_err <= 1'b1;
      end else if (err_clr) begin
        cpl_err <= 1'b0;
      end else begin
        cpl_err <= cpl_err;
      end
      for (int c = 0; c < DMA_CHN_NUM; c++) begin
        chn_ostd_cnt[c] <= chn_nxt_s[c];
        atx_done[c]     <= chn_dec_s[c];
      end
    end
  end

endmodule

// File: tb/tb_adma_atx_ostd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adma_atx_ostd_ctrl
// Directed self-checking bench for adma_atx_ostd_ctrl with default
// parameters (4 channels, global limit 4, per-channel limit 2).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked after a further settle, registered outputs right after the edge.
// ---------------------------------------------------------------------------
module tb_adma_atx_ostd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] bwd_atx_chn_id;
  logic       bwd_atx_vld;
  logic       bwd_atx_rdy;
  logic       fwd_atx_vld;
  logic       fwd_atx_rdy;
  logic [4:0] atx_id [0:3];
  logic [4:0] cpl_id;
  logic       cpl_vld;
  logic       atx_done [0:3];
  logic [1:0] chn_ostd_cnt [0:3];
  logic [2:0] ostd_cnt;
  logic       idle;
  logic       cpl_err;
  logic       err_clr;

  int passed = 0;
  int total  = 0;

  adma_atx_ostd_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .bwd_atx_chn_id (bwd_atx_chn_id),
    .bwd_atx_vld    (bwd_atx_vld),
    .bwd_atx_rdy    (bwd_atx_rdy),
    .fwd_atx_vld    (fwd_atx_vld),
    .fwd_atx_rdy    (fwd_atx_rdy),
    .atx_id         (atx_id),
    .cpl_id         (cpl_id),
    .cpl_vld        (cpl_vld),
    .atx_done       (atx_done),
    .chn_ostd_cnt   (chn_ostd_cnt),
    .ostd_cnt       (ostd_cnt),
    .idle           (idle),
    .cpl_err        (cpl_err),
    .err_clr        (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_cnts(input string tag, input int c0, input int c1,
                          input int c2, input int c3, input int tot);
    chk({tag, "_ch0"}, 32'(chn_ostd_cnt[0]), 32'(c0));
    chk({tag, "_ch1"}, 32'(chn_ostd_cnt[1]), 32'(c1));
    chk({tag, "_ch2"}, 32'(chn_ostd_cnt[2]), 32'(c2));
    chk({tag, "_ch3"}, 32'(chn_ostd_cnt[3]), 32'(c3));
    chk({tag, "_ostd"}, 32'(ostd_cnt), 32'(tot));
  endtask

  task automatic chk_done(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {atx_done[3], atx_done[2], atx_done[1], atx_done[0]};
    chk(tag, 32'(obs), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; bwd_atx_chn_id = 2'd0; bwd_atx_vld = 1'b0; fwd_atx_rdy = 1'b0;
    cpl_id = 5'd0; cpl_vld = 1'b0; err_clr = 1'b0;
    atx_id[0] = 5'd1; atx_id[1] = 5'd2; atx_id[2] = 5'd3; atx_id[3] = 5'd4;
    #12;
    // Reset state
    chk_cnts("rst", 0, 0, 0, 0, 0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_err", 32'(cpl_err), 32'd0);
    chk("rst_fwd_vld", 32'(fwd_atx_vld), 32'd0);
    chk("rst_bwd_rdy", 32'(bwd_atx_rdy), 32'd0);
    chk_done("rst_done", 4'b0000);
    tick();
    rst = 1'b0;
    tick();

    // Single issue on ch0
    bwd_atx_vld = 1'b1; bwd_atx_chn_id = 2'd0; fwd_atx_rdy = 1'b1;
    settle();
    chk("iss0_bwd_rdy", 32'(bwd_atx_rdy), 32'd1);
    chk("iss0_fwd_vld", 32'(fwd_atx_vld), 32'd1);
    tick();
    chk_cnts("iss0", 1, 0, 0, 0, 1);
    chk("iss0_idle", 32'(idle), 32'd0);

    // Simultaneous issue and completion on ch0 (count 1)
    cpl_vld = 1'b1; cpl_id = 5'd1;
    tick();
    bwd_atx_vld = 1'b0; cpl_vld = 1'b0;
    chk_cnts("simul", 1, 0, 0, 0, 1);
    chk_done("simul_done", 4'b0001);
    tick();
    chk_done("simul_done_clr", 4'b0000);

    // Issue stalled by fwd_atx_rdy low: valid passes, no handshake
    bwd_atx_vld = 1'b1; bwd_atx_chn_id = 2'd3; fwd_atx_rdy = 1'b0;
    settle();
    chk("nordy_fwd_vld", 32'(fwd_atx_vld), 32'd1);
    chk("nordy_bwd_rdy", 32'(bwd_atx_rdy), 32'd0);
    tick();
    bwd_atx_vld = 1'b0; fwd_atx_rdy = 1'b1;
    chk_cnts("nordy", 1, 0, 0, 0, 1);

    // Drain ch0
    cpl_vld = 1'b1; cpl_id = 5'd1;
    tick();
    cpl_vld = 1'b0;
    chk_cnts("drain0", 0, 0, 0, 0, 0);
    chk("drain0_idle", 32'(idle), 32'd1);
    chk_done("drain0_done", 4'b0001);

    // Per-channel limit on ch1
    bwd_atx_vld = 1'b1; bwd_atx_chn_id = 2'd1;
    tick();
    tick();
    chk_cnts("chlim_full", 0, 2, 0, 0, 2);
    settle();
    chk("chlim_stall_rdy", 32'(bwd_atx_rdy), 32'd0);
    chk("chlim_stall_vld", 32'(fwd_atx_vld), 32'd0);
    cpl_vld = 1'b1; cpl_id = 5'd2;
    settle();
    chk("chlim_cpl_same_cyc_rdy", 32'(bwd_atx_rdy), 32'd0);
    tick();
    cpl_vld = 1'b0;
    chk_cnts("chlim_cpl", 0, 1, 0, 0, 1);
    chk_done("chlim_done", 4'b0010);
    settle();
    chk("chlim_third_rdy", 32'(bwd_atx_rdy), 32'd1);
    tick();
    bwd_atx_vld = 1'b0;
    chk_cnts("chlim_third", 0, 2, 0, 0, 2);
    chk_done("chlim_done_clr", 4'b0000);
    cpl_vld = 1'b1; cpl_id = 5'd2;
    tick();
    tick();
    cpl_vld = 1'b0;
    chk_cnts("chlim_drain", 0, 0, 0, 0, 0);

    // Global limit: one issue per channel
    bwd_atx_vld = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bwd_atx_chn_id = 2'(c);
      tick();
    end
    chk_cnts("glim_full", 1, 1, 1, 1, 4);
    bwd_atx_chn_id = 2'd0;
    settle();
    chk("glim_stall_rdy", 32'(bwd_atx_rdy), 32'd0);
    chk("glim_stall_vld", 32'(fwd_atx_vld), 32'd0);
    cpl_vld = 1'b1; cpl_id = 5'd3;
    settle();
    chk("glim_cpl_same_cyc_rdy", 32'(bwd_atx_rdy), 32'd0);
    tick();
    cpl_vld = 1'b0;
    chk_cnts("glim_cpl", 1, 1, 0, 1, 3);
    chk_done("glim_done", 4'b0100);
    settle();
    chk("glim_accept_rdy", 32'(bwd_atx_rdy), 32'd1);
    tick();
    bwd_atx_vld = 1'b0;
    chk_cnts("glim_accept", 2, 1, 0, 1, 4);

    // Surplus completion: ch2 ID with ch2 count 0
    cpl_vld = 1'b1; cpl_id = 5'd3;
    tick();
    chk("err_surplus", 32'(cpl_err), 32'd1);
    chk_done("err_surplus_done", 4'b0000);
    chk_cnts("err_surplus", 2, 1, 0, 1, 4);
    // Unmatched ID
    cpl_id = 5'd9;
    tick();
    cpl_vld = 1'b0;
    chk("err_nomatch", 32'(cpl_err), 32'd1);
    chk_done("err_nomatch_done", 4'b0000);
    chk_cnts("err_nomatch", 2, 1, 0, 1, 4);
    // Clear
    err_clr = 1'b1;
    tick();
    chk("err_clr", 32'(cpl_err), 32'd0);
    // Clear together with a new bad completion: set wins
    cpl_vld = 1'b1; cpl_id = 5'd9;
    tick();
    cpl_vld = 1'b0;
    chk("err_set_wins", 32'(cpl_err), 32'd1);
    tick();
    err_clr = 1'b0;
    chk("err_clr2", 32'(cpl_err), 32'd0);

    // Duplicate IDs: drain ch0 first, then share ID 5 between ch0 and ch2
    cpl_vld = 1'b1; cpl_id = 5'd1;
    tick();
    tick();
    cpl_vld = 1'b0;
    chk_cnts("dup_prep", 0, 1, 0, 1, 2);
    atx_id[0] = 5'd5; atx_id[2] = 5'd5;
    bwd_atx_vld = 1'b1; bwd_atx_chn_id = 2'd2;
    tick();
    bwd_atx_vld = 1'b0;
    chk_cnts("dup_iss", 0, 1, 1, 1, 3);
    cpl_vld = 1'b1; cpl_id = 5'd5;
    tick();
    cpl_vld = 1'b0;
    chk_done("dup_done", 4'b0100);
    chk_cnts("dup_cpl", 0, 1, 0, 1, 2);
    chk("dup_err", 32'(cpl_err), 32'd0);

    // Reset mid-operation discards in-flight state
    rst = 1'b1;
    settle();
    chk_cnts("midrst", 0, 0, 0, 0, 0);
    chk("midrst_idle", 32'(idle), 32'd1);
    tick();
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
